// File: rtl/alu_serdes_pkg.sv
// Shared types and defaults for the serial ALU front/back end.
// Opcode values must match the alu core decoder.
package alu_serdes_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpOr   = 3'd2,
    OpAnd  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5,
    OpCmp  = 3'd6,
    OpShl  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCapt,
    StDone
  } state_e;

endpackage

// File: rtl/alu_serdes_if.sv
// Request, serial-ALU and result signals of alu_serdes bundled as one interface.
// slave is the alu_serdes side; master is the requester / alu core / consumer side.
interface alu_serdes_if #(
  parameter int unsigned Width = alu_serdes_pkg::DefaultWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [Width-1:0] in_a;
  logic [Width-1:0] in_b;

  logic             alu_rst_n;
  logic [2:0]       alu_opcode;
  logic             alu_a;
  logic             alu_b;
  logic             alu_y;
  logic             alu_c;

  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_y;
  logic             out_c;

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_y, alu_c, out_ready,
    output in_ready, alu_rst_n, alu_opcode, alu_a, alu_b, out_valid, out_y, out_c
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_y, alu_c, out_ready,
    input  in_ready, alu_rst_n, alu_opcode, alu_a, alu_b, out_valid, out_y, out_c
  );

endinterface

// File: rtl/alu_serdes_serial_shreg.sv
// Right-shifting PISO/SIPO register: parallel load wins over shift; bit 0 is the serial output.
module alu_serdes_serial_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] par_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [Width-1:0] par_o
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = par_i;
    end else if (shift_i) begin
      q_d = {ser_i, q_q[Width-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign ser_o = q_q[0];
  assign par_o = q_q;

endmodule

// File: rtl/alu_serdes.sv
// Serialises an operand pair LSB-first into the bit-serial ALU and reassembles its result.
// One operation in flight; IDLE -> SHIFT (Width cycles) -> CAPT -> DONE.
module alu_serdes
  import alu_serdes_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input logic         clk,
  input logic         rst_n,
  alu_serdes_if.slave bus
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic [Width-1:0] out_y_q, out_y_d;
  logic             out_c_q, out_c_d;

  logic             load;
  logic             shift;
  logic             a_ser;
  logic             b_ser;
  logic [Width-1:0] res_par;
  logic [Width-1:0] a_par_unused;
  logic [Width-1:0] b_par_unused;
  logic             res_ser_unused;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_y_d = out_y_q;
    out_c_d = out_c_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          op_d    = alu_op_e'(bus.in_op);
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        // ALU carry already reflects all Width bits; its update this cycle is discarded.
        out_y_d = res_par;
        out_c_d = bus.alu_c;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpAdd;
      out_y_q <= '0;
      out_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_y_q <= out_y_d;
      out_c_q <= out_c_d;
    end
  end

  alu_serdes_serial_shreg #(.Width(Width)) u_shreg_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .shift_i(shift),
    .par_i  (bus.in_a),
    .ser_i  (1'b0),
    .ser_o  (a_ser),
    .par_o  (a_par_unused)
  );

  alu_serdes_serial_shreg #(.Width(Width)) u_shreg_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .shift_i(shift),
    .par_i  (bus.in_b),
    .ser_i  (1'b0),
    .ser_o  (b_ser),
    .par_o  (b_par_unused)
  );

  // Result fills from the top so the first serial bit lands in bit 0 after Width shifts.
  alu_serdes_serial_shreg #(.Width(Width)) u_shreg_res (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .shift_i(shift),
    .par_i  ('0),
    .ser_i  (bus.alu_y),
    .ser_o  (res_ser_unused),
    .par_o  (res_par)
  );

  // ALU is held in clear whenever no operation is streaming, so no carry survives between ops.
  assign bus.alu_rst_n  = (state_q == StShift) || (state_q == StCapt);
  assign bus.alu_opcode = op_q;
  assign bus.alu_a      = (state_q == StShift) && a_ser;
  assign bus.alu_b      = (state_q == StShift) && b_ser;
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_y      = out_y_q;
  assign bus.out_c      = out_c_q;

endmodule

// File: tb/tb_alu_serdes.sv
// Bench for alu_serdes: emulates the bit-serial ALU core and checks every returned result
// against a word-level reference model, plus directed vectors with literal expectations.
module tb_alu_serdes;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_pop = 0;
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serdes_if #(.Width(W)) bus ();

  alu_serdes #(.Width(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Word-level meaning of each opcode: result and final flag.
  function automatic res_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    res_t         r;
    logic [W:0]   s;
    s = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[W-1:0]; r.c = s[W]; end
      3'd1: begin r.y = a - b;    r.c = (a < b);  end
      3'd2: begin r.y = a | b;    r.c = |(a | b); end
      3'd3: begin r.y = a & b;    r.c = |(a & b); end
      3'd4: begin r.y = a ^ b;    r.c = |(a ^ b); end
      3'd5: begin r.y = ~(a ^ b); r.c = |(~(a ^ b)); end
      3'd6: begin r.y = a;        r.c = (a >= b); end
      default: begin r.y = a << 1; r.c = a[W-1]; end
    endcase
    return r;
  endfunction

  // Bit-serial ALU core emulation: one flag/carry bit of state, cleared while alu_rst_n is low.
  logic f_q, f_d, sa, sb_bit, ybit;

  always_comb begin
    sa     = bus.alu_a;
    sb_bit = bus.alu_b;
    f_d    = f_q;
    ybit   = 1'b0;
    case (bus.alu_opcode)
      3'd0: begin ybit = sa ^ sb_bit ^ f_q; f_d = (sa & sb_bit) | (sa & f_q) | (sb_bit & f_q); end
      3'd1: begin ybit = sa ^ sb_bit ^ f_q; f_d = (~sa & sb_bit) | (~sa & f_q) | (sb_bit & f_q); end
      3'd2: begin ybit = sa | sb_bit;     f_d = f_q | ybit; end
      3'd3: begin ybit = sa & sb_bit;     f_d = f_q | ybit; end
      3'd4: begin ybit = sa ^ sb_bit;     f_d = f_q | ybit; end
      3'd5: begin ybit = ~(sa ^ sb_bit);  f_d = f_q | ybit; end
      3'd6: begin ybit = sa;              f_d = (~sa & sb_bit) | (~sa & f_q) | (sb_bit & f_q); end
      default: begin ybit = f_q;          f_d = sa; end
    endcase
    bus.alu_y = ybit;
    bus.alu_c = (bus.alu_opcode == 3'd6) ? ~f_q : f_q;
  end

  always_ff @(posedge clk) f_q <= bus.alu_rst_n ? f_d : 1'b0;

  // Scoreboard: push on accept, compare whenever out_valid, pop on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: out_valid with out_y=0x%0h, required no result", bus.out_y);
        end else begin
          check("sb_out_y", 32'(bus.out_y), 32'(sb[0].y));
          check("sb_out_c", 32'(bus.out_c), 32'(sb[0].c));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_pop++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ref_model(bus.in_op, bus.in_a, bus.in_b));
        n_push++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int acc_cyc);
    int n = 0;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #2;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ey, input logic ec);
    int t, lat;
    send(op, a, b, t);
    wait_result(lat);
    check({name, "_y"}, 32'(bus.out_y), 32'(ey));
    check({name, "_c"}, 32'(bus.out_c), 32'(ec));
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, lat;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_y", 32'(bus.out_y), 0);
    check("rst_out_c", 32'(bus.out_c), 0);
    check("rst_alu_rst_n", 32'(bus.alu_rst_n), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ADD with latency: out_valid seen at the (Width+2)th edge after accept.
    send(3'd0, 8'hC8, 8'h64, t0);
    wait_result(lat);
    check("add_latency", 32'(lat), W + 2);
    check("add_y", 32'(bus.out_y), 'h2C);
    check("add_c", 32'(bus.out_c), 1);
    @(posedge clk);
    #2;

    directed("sub", 3'd1, 8'h10, 8'h01, 8'h0F, 1'b0);
    directed("or", 3'd2, 8'h00, 8'h00, 8'h00, 1'b0);
    directed("cmp", 3'd6, 8'h05, 8'h03, 8'h05, 1'b1);
    directed("xnor", 3'd5, 8'h5A, 8'h5A, 8'hFF, 1'b1);

    // Back-to-back: carry from the first op must not reach the second.
    send(3'd0, 8'hFF, 8'h01, t0);
    wait_result(lat);
    check("b2b_add_y", 32'(bus.out_y), 'h00);
    check("b2b_add_c", 32'(bus.out_c), 1);
    @(posedge clk);
    #2;
    send(3'd3, 8'hFF, 8'h0F, t1);
    check("b2b_spacing", 32'(t1 - t0), W + 3);
    wait_result(lat);
    check("b2b_and_y", 32'(bus.out_y), 'h0F);
    check("b2b_and_c", 32'(bus.out_c), 1);
    @(posedge clk);
    #2;

    // Consumer stalls in DONE; in_valid pulses there must be ignored.
    bus.out_ready = 1'b0;
    send(3'd7, 8'h81, 8'h00, t0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      bus.in_op    = 3'd0;
      bus.in_a     = 8'hFF;
      bus.in_b     = 8'hFF;
      bus.in_valid = (i % 2 == 1);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_out_y", 32'(bus.out_y), 'h02);
      check("hold_out_c", 32'(bus.out_c), 1);
    end
    @(posedge clk);
    #2;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("post_done_in_ready", 32'(bus.in_ready), 1);
    check("post_done_keep_y", 32'(bus.out_y), 'h02);
    check("post_done_keep_c", 32'(bus.out_c), 1);
    repeat (3) @(negedge clk);
    check("no_queued_op", 32'(bus.out_valid), 0);

    // Asynchronous reset during SHIFT at cnt=3 drops the operation.
    @(posedge clk);
    #2;
    send(3'd4, 8'h33, 8'h44, t0);
    repeat (3) @(posedge clk);
    #2;
    check("shift_alu_rst_n", 32'(bus.alu_rst_n), 1);
    check("shift_alu_opcode", 32'(bus.alu_opcode), 4);
    rst_n = 1'b0;
    sb.delete();
    n_push--;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_alu_rst_n", 32'(bus.alu_rst_n), 0);
    check("midrst_out_y", 32'(bus.out_y), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    directed("rst_add", 3'd0, 8'h01, 8'h01, 8'h02, 1'b0);

    // Random operations, some with a stalled consumer; checked by the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send(rop, ra, rb, t0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      wait_result(lat);
      if (!bus.out_ready) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #2;
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    check("results_returned", 32'(n_pop), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
